// File: rtl/coa_pkg.sv
// rtl/coa_pkg.sv - shared state encoding for the bit-serial arithmetic blocks
package coa_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - 1-bit combinational full subtractor (a - b - bin)
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_nbit.sv
// rtl/serial_subtractor_nbit.sv - bit-serial unsigned N-bit subtractor, LSB first
module serial_subtractor_nbit
    import coa_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Diff,
    output logic         Borrow
);

    localparam int CW = $clog2(N) + 1;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [N-1:0]  sd;
    logic [N-1:0]  sd_shift;
    logic [CW-1:0] cnt;
    logic          bor;
    logic          d;
    logic          bout;
    logic          last;

    assign last = (cnt == CW'(N - 1));

    full_subtractor u_fs (
        .a   (sa[0]),
        .b   (sb[0]),
        .bin (bor),
        .d   (d),
        .bout(bout)
    );

    // New difference bit enters at the MSB; a 1-bit build has nothing to shift.
    generate
        if (N == 1) begin : g_sd_one
            assign sd_shift = d;
        end else begin : g_sd_many
            assign sd_shift = {d, sd[N-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last)  state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN) || (state == ST_DONE);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            bor    <= 1'b0;
            cnt    <= '0;
            Diff   <= '0;
            Borrow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sa  <= A;
                        sb  <= B;
                        sd  <= '0;
                        bor <= 1'b0;
                        cnt <= '0;
                    end
                end
                ST_RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sd  <= sd_shift;
                    bor <= bout;
                    cnt <= cnt + 1'b1;
                    // Results update only here, so they hold between completions.
                    if (last) begin
                        Diff   <= sd_shift;
                        Borrow <= bout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// tb/tb_serial_subtractor_nbit.sv - scoreboard bench for the serial subtractor (N=8 and N=1)
module tb_serial_subtractor_nbit;

    typedef struct {
        logic [7:0] d;
        logic       b;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       borrow1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0;
    exp_t q[$];
    exp_t q1[$];

    serial_subtractor_nbit #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
        .busy(busy), .done(done), .Diff(diff), .Borrow(borrow)
    );

    serial_subtractor_nbit #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .Diff(diff1), .Borrow(borrow1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge rst_n) busy_run = 0;

    // N=8 monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_run++;
            if (done) begin
                exp_t e;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done diff=%h borrow=%b cyc=%0d", diff, borrow, cyc);
                end else begin
                    e = q.pop_front();
                    if (diff !== e.d || borrow !== e.b) begin
                        errors++;
                        $display("FAIL result got diff=%h borrow=%b want diff=%h borrow=%b", diff, borrow, e.d, e.b);
                    end
                    checks++;
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL done_cycle got %0d want %0d", cyc, e.cyc);
                    end
                    checks++;
                    if (busy_run != 9) begin
                        errors++;
                        $display("FAIL busy_len got %0d want 9", busy_run);
                    end
                end
                busy_run = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done1) begin
            exp_t e;
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL n1_unexpected_done diff=%b borrow=%b", diff1, borrow1);
            end else begin
                e = q1.pop_front();
                if (diff1 !== e.d[0] || borrow1 !== e.b || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL n1_result got diff=%b borrow=%b cyc=%0d want diff=%b borrow=%b cyc=%0d",
                             diff1, borrow1, cyc, e.d[0], e.b, e.cyc);
                end
            end
        end
    end

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q.size() == 0 && q1.size() == 0 && !busy && !busy1) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d pending_n1=%0d", q.size(), q1.size());
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed, input logic eb);
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b;
        q.push_back('{d: ed, b: eb, cyc: cyc + 9});
        @(negedge clk);
        start = 1'b0; a_in = ~a; b_in = ~b;
    endtask

    task automatic issue1(input logic a, input logic b, input logic ed, input logic eb);
        @(negedge clk);
        start1 = 1'b1; a1 = a; b1 = b;
        q1.push_back('{d: {7'd0, ed}, b: eb, cyc: cyc + 2});
        @(negedge clk);
        start1 = 1'b0; a1 = ~a; b1 = ~b;
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0 ||
            busy1 !== 1'b0 || done1 !== 1'b0 || diff1 !== 1'b0 || borrow1 !== 1'b0) begin
            errors++;
            $display("FAIL %s got busy=%b done=%b diff=%h borrow=%b n1:%b%b%b%b want all 0",
                     name, busy, done, diff, borrow, busy1, done1, diff1, borrow1);
        end
    endtask

    initial begin
        int c;
        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset_state");
        rst_n = 1'b1;

        issue(8'h5A, 8'h3C, 8'h1E, 1'b0); drain();
        issue(8'h3C, 8'h5A, 8'hE2, 1'b1); drain();
        issue(8'hFF, 8'hFF, 8'h00, 1'b0); drain();
        issue(8'h80, 8'h7F, 8'h01, 1'b0); drain();
        issue(8'h00, 8'h01, 8'hFF, 1'b1); drain();

        // Result must hold while idle.
        repeat (4) @(negedge clk);
        checks++;
        if (diff !== 8'hFF || borrow !== 1'b1) begin
            errors++;
            $display("FAIL hold got diff=%h borrow=%b want diff=ff borrow=1", diff, borrow);
        end

        // Start pulse mid-RUN with new operands must be ignored.
        issue(8'h5A, 8'h3C, 8'h1E, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1; a_in = 8'h12; b_in = 8'h34;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset during RUN cycle 4: discard in flight, no done.
        issue(8'h3C, 8'h5A, 8'hE2, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        void'(q.pop_back());
        #1;
        check_idle_zero("reset_in_run");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(8'h5A, 8'h3C, 8'h1E, 1'b0); drain();

        // start held for 30 cycles: three back-to-back operations.
        @(negedge clk);
        c = cyc;
        start = 1'b1; a_in = 8'h10; b_in = 8'h01;
        for (int k = 0; k < 3; k++) q.push_back('{d: 8'h0F, b: 1'b0, cyc: c + 9 + 10 * k});
        repeat (30) @(negedge clk);
        start = 1'b0;
        drain();

        issue1(1'b0, 1'b1, 1'b1, 1'b1); drain();
        issue1(1'b1, 1'b0, 1'b1, 1'b0); drain();
        issue1(1'b1, 1'b1, 1'b0, 1'b0); drain();

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
